// File: rtl/insn_encoder_pkg.sv
// -----------------------------------------------------------------------------
// Common -- shared types and constants for the RV32I instruction encoder.
//
// Contents:
//   ImmFmt      : instruction encoding format selector (3 bits; code 7 unused)
//   NOP_INSN    : word emitted in place of any request that fails its check
//   insn_req_t  : one captured encode request (format plus all raw fields)
// -----------------------------------------------------------------------------
package Common;

  typedef enum logic [2:0] {
    FMT_R      = 3'd0,
    FMT_I      = 3'd1,
    FMT_ISHIFT = 3'd2,
    FMT_S      = 3'd3,
    FMT_B      = 3'd4,
    FMT_U      = 3'd5,
    FMT_J      = 3'd6
  } ImmFmt;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    ImmFmt       fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } insn_req_t;

endpackage

// File: rtl/insn_encoder_if.sv
// -----------------------------------------------------------------------------
// insn_encoder_if -- request/response bundle of the instruction encoder.
//
// Request side (valid/ready): in_valid, in_ready, in_fmt, in_opcode, in_rd,
//   in_rs1, in_rs2, in_funct3, in_funct7, in_imm.
// Response side (valid/ready): out_valid, out_ready, out_insn, out_err.
//
// Modports:
//   master : the client -- issues requests and consumes encoded words
//   slave  : the encoder
// -----------------------------------------------------------------------------
interface insn_encoder_if;
  import Common::*;

  logic        in_valid;
  logic        in_ready;
  ImmFmt       in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic        out_err;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_insn, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_insn, out_err
  );

endinterface

// File: rtl/insn_encoder_range_check.sv
// -----------------------------------------------------------------------------
// imm_range_check -- combinational immediate legality check.
//
// Ports:
//   fmt_i : encoding format of the request
//   imm_i : two's complement immediate (byte offset or value)
//   ok_o  : 1 when the immediate is representable in that format
//
// Branch and jump offsets must also be even, since bit 0 is not encoded.
// Upper immediates must have their low 12 bits clear. R-type ignores the
// immediate. Unused format codes are never ok.
// -----------------------------------------------------------------------------
module imm_range_check
  import Common::*;
(
  input  ImmFmt       fmt_i,
  input  logic [31:0] imm_i,
  output logic        ok_o
);

  logic signed [31:0] simm;
  assign simm = $signed(imm_i);

  // NOTE: every output of a combinational block gets a default before the
  // case statement, so no path can leave it unassigned and infer a latch.
  always_comb begin
    ok_o = 1'b0;
    case (fmt_i)
      FMT_R:        ok_o = 1'b1;
      FMT_I, FMT_S: ok_o = (simm >= -32'sd2048) && (simm <= 32'sd2047);
      // Unsigned compare: negative shift amounts look huge and fail.
      FMT_ISHIFT:   ok_o = (imm_i <= 32'd31);
      FMT_B:        ok_o = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm_i[0];
      FMT_J:        ok_o = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm_i[0];
      FMT_U:        ok_o = (imm_i[11:0] == 12'd0);
      default:      ok_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/insn_encoder.sv
// -----------------------------------------------------------------------------
// insn_encoder -- two-stage RV32I instruction word encoder.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   bus       : insn_encoder_if.slave -- request in, encoded word out
//   err_count : saturating count of erroneous words handed to the consumer
//
// Stage 1 captures the request together with its immediate range check.
// Stage 2 holds the assembled word (or NOP plus out_err on a failed check).
// Each stage loads when it is empty or when its contents move downstream, so
// with out_ready held high one request is accepted every cycle and its word
// appears two clock edges after the request is presented.
// -----------------------------------------------------------------------------
module insn_encoder (
  input  logic           clk,
  input  logic           rst,
  insn_encoder_if.slave  bus,
  output logic [15:0]    err_count
);
  import Common::*;

  // ---------------------------------------------------------------------------
  // Request capture and range check
  // ---------------------------------------------------------------------------
  insn_req_t req_in;
  logic      req_ok;

  always_comb begin
    req_in        = '0;
    req_in.fmt    = bus.in_fmt;
    req_in.opcode = bus.in_opcode;
    req_in.rd     = bus.in_rd;
    req_in.rs1    = bus.in_rs1;
    req_in.rs2    = bus.in_rs2;
    req_in.funct3 = bus.in_funct3;
    req_in.funct7 = bus.in_funct7;
    req_in.imm    = bus.in_imm;
  end

  imm_range_check u_range_check (
    .fmt_i (bus.in_fmt),
    .imm_i (bus.in_imm),
    .ok_o  (req_ok)
  );

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic        s1_valid_q, s1_valid_d;
  logic        s1_ok_q, s1_ok_d;
  insn_req_t   s1_req_q, s1_req_d;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_insn_q, out_insn_d;
  logic        out_err_q, out_err_d;

  logic [15:0] err_count_q, err_count_d;

  logic        s2_ready;
  logic        s1_ready;
  logic [31:0] assembled;

  // Stage 2 can take a word when it is empty or its word is being consumed;
  // stage 1 likewise when empty or when it is handing over to stage 2.
  assign s2_ready = !out_valid_q || bus.out_ready;
  assign s1_ready = !s1_valid_q  || s2_ready;

  // Forced low while reset is asserted so nothing appears accepted that the
  // reset is about to discard.
  assign bus.in_ready = !rst && s1_ready;

  // ---------------------------------------------------------------------------
  // Field assembly from the stage-1 request
  // ---------------------------------------------------------------------------
  always_comb begin
    assembled = NOP_INSN;
    case (s1_req_q.fmt)
      FMT_R:      assembled = {s1_req_q.funct7, s1_req_q.rs2, s1_req_q.rs1,
                               s1_req_q.funct3, s1_req_q.rd, s1_req_q.opcode};
      FMT_I:      assembled = {s1_req_q.imm[11:0], s1_req_q.rs1,
                               s1_req_q.funct3, s1_req_q.rd, s1_req_q.opcode};
      FMT_ISHIFT: assembled = {s1_req_q.funct7, s1_req_q.imm[4:0], s1_req_q.rs1,
                               s1_req_q.funct3, s1_req_q.rd, s1_req_q.opcode};
      FMT_S:      assembled = {s1_req_q.imm[11:5], s1_req_q.rs2, s1_req_q.rs1,
                               s1_req_q.funct3, s1_req_q.imm[4:0], s1_req_q.opcode};
      FMT_B:      assembled = {s1_req_q.imm[12], s1_req_q.imm[10:5],
                               s1_req_q.rs2, s1_req_q.rs1, s1_req_q.funct3,
                               s1_req_q.imm[4:1], s1_req_q.imm[11],
                               s1_req_q.opcode};
      FMT_U:      assembled = {s1_req_q.imm[31:12], s1_req_q.rd, s1_req_q.opcode};
      FMT_J:      assembled = {s1_req_q.imm[20], s1_req_q.imm[10:1],
                               s1_req_q.imm[11], s1_req_q.imm[19:12],
                               s1_req_q.rd, s1_req_q.opcode};
      default:    assembled = NOP_INSN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_ok_d     = s1_ok_q;
    s1_req_d    = s1_req_q;
    out_valid_d = out_valid_q;
    out_insn_d  = out_insn_q;
    out_err_d   = out_err_q;
    err_count_d = err_count_q;

    if (s1_ready) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_req_d = req_in;
        s1_ok_d  = req_ok;
      end
    end

    // When stalled, out_valid/out_insn/out_err simply keep their values.
    if (s2_ready) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_insn_d = s1_ok_q ? assembled : NOP_INSN;
        out_err_d  = !s1_ok_q;
      end
    end

    // Counted as the erroneous word leaves, saturating instead of wrapping.
    if (out_valid_q && bus.out_ready && out_err_q && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge next-state value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_insn_q  <= 32'd0;
      out_err_q   <= 1'b0;
      err_count_q <= 16'd0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_insn_q  <= out_insn_d;
      out_err_q   <= out_err_d;
      err_count_q <= err_count_d;
    end
  end

  // NOTE: the stage-1 payload is qualified by s1_valid_q, so it is left out
  // of reset; only the control and visible output registers are cleared.
  always_ff @(posedge clk) begin
    s1_req_q <= s1_req_d;
    s1_ok_q  <= s1_ok_d;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_insn  = out_insn_q;
  assign bus.out_err   = out_err_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_insn_encoder.sv
// -----------------------------------------------------------------------------
// tb_insn_encoder -- directed self-checking bench for insn_encoder.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_insn_encoder;
  import Common::*;

  typedef struct {
    ImmFmt       fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } tb_req_t;

  typedef struct {
    ImmFmt       fmt;
    logic [6:0]  op;
    logic [31:0] imm;
    logic [31:0] exp;
    logic        err;
  } bnd_vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] err_count;
  int          n_tests = 0;
  int          n_fail  = 0;

  insn_encoder_if bus ();

  insn_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic tb_req_t mk(input ImmFmt fmt, input logic [6:0] op,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] imm);
    tb_req_t r;
    r.fmt = fmt; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.f3 = f3; r.f7 = f7; r.imm = imm;
    return r;
  endfunction

  task automatic drive(input tb_req_t r);
    bus.in_fmt    = r.fmt;
    bus.in_opcode = r.op;
    bus.in_rd     = r.rd;
    bus.in_rs1    = r.rs1;
    bus.in_rs2    = r.rs2;
    bus.in_funct3 = r.f3;
    bus.in_funct7 = r.f7;
    bus.in_imm    = r.imm;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Sends one request with out_ready high and returns the word it produced.
  // ok is 0 if the request was not accepted or no word came out in time.
  task automatic run_one(input tb_req_t r, output logic [31:0] insn,
                         output logic err, output bit ok);
    bit acc = 1'b0;
    bit got = 1'b0;
    insn = '0;
    err  = 1'b0;
    drive(r);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (bus.in_ready) acc = 1'b1;
      next_cycle();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && acc && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got  = 1'b1;
        insn = bus.out_insn;
        err  = bus.out_err;
      end
      next_cycle();
    end
    ok = acc && got;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(mk(FMT_R, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0));
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready_low: got %0b want 0", bus.in_ready);
    end
    next_cycle();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid);
    end
    n_tests++;
    if (bus.out_insn !== 32'd0) begin
      n_fail++; $display("FAIL reset_out_insn: got %08h want 00000000", bus.out_insn);
    end
    n_tests++;
    if (bus.out_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_err: got %0b want 0", bus.out_err);
    end
    n_tests++;
    if (err_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_err_count: got %0d want 0", err_count);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready_after: got %0b want 1", bus.in_ready);
    end
    next_cycle();
  endtask

  task automatic test_i_latency();
    drive(mk(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF));
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL i_accept: in_ready got %0b want 1", bus.in_ready);
    end
    next_cycle();
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL i_latency_early: out_valid got %0b want 0", bus.out_valid);
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_insn !== 32'hFFF0_0093 || bus.out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL i_word: valid=%0b insn=%08h err=%0b want valid=1 insn=fff00093 err=0",
               bus.out_valid, bus.out_insn, bus.out_err);
    end
    next_cycle();
  endtask

  task automatic test_b_format();
    logic [31:0] insn;
    logic        err;
    bit          ok;
    run_one(mk(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8), insn, err, ok);
    n_tests++;
    if (!ok || insn !== 32'h0020_8463 || err !== 1'b0) begin
      n_fail++; $display("FAIL b_imm8: ok=%0b insn=%08h err=%0b want insn=00208463 err=0", ok, insn, err);
    end
    run_one(mk(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3), insn, err, ok);
    n_tests++;
    if (!ok || insn !== 32'h0000_0013 || err !== 1'b1) begin
      n_fail++; $display("FAIL b_imm3_odd: ok=%0b insn=%08h err=%0b want insn=00000013 err=1", ok, insn, err);
    end
    n_tests++;
    if (err_count !== 16'd1) begin
      n_fail++; $display("FAIL b_err_count: got %0d want 1", err_count);
    end
  endtask

  task automatic test_j_u_format();
    logic [31:0] insn;
    logic        err;
    bit          ok;
    run_one(mk(FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048), insn, err, ok);
    n_tests++;
    if (!ok || insn !== 32'h0010_00EF || err !== 1'b0) begin
      n_fail++; $display("FAIL j_imm2048: ok=%0b insn=%08h err=%0b want insn=001000ef err=0", ok, insn, err);
    end
    run_one(mk(FMT_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000), insn, err, ok);
    n_tests++;
    if (!ok || insn !== 32'h1234_52B7 || err !== 1'b0) begin
      n_fail++; $display("FAIL u_lui: ok=%0b insn=%08h err=%0b want insn=123452b7 err=0", ok, insn, err);
    end
  endtask

  task automatic test_r_s_shift();
    logic [31:0] insn;
    logic        err;
    bit          ok;
    run_one(mk(FMT_R, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0), insn, err, ok);
    n_tests++;
    if (!ok || insn !== 32'h0020_81B3 || err !== 1'b0) begin
      n_fail++; $display("FAIL r_add: ok=%0b insn=%08h err=%0b want insn=002081b3 err=0", ok, insn, err);
    end
    run_one(mk(FMT_S, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8), insn, err, ok);
    n_tests++;
    if (!ok || insn !== 32'h0020_A423 || err !== 1'b0) begin
      n_fail++; $display("FAIL s_sw: ok=%0b insn=%08h err=%0b want insn=0020a423 err=0", ok, insn, err);
    end
    run_one(mk(FMT_ISHIFT, 7'h13, 5'd5, 5'd6, 5'd0, 3'd5, 7'h20, 32'd3), insn, err, ok);
    n_tests++;
    if (!ok || insn !== 32'h4033_5293 || err !== 1'b0) begin
      n_fail++; $display("FAIL ishift_srai: ok=%0b insn=%08h err=%0b want insn=40335293 err=0", ok, insn, err);
    end
  endtask

  // Range edges: register fields zero so each word is immediate + opcode.
  task automatic test_boundaries();
    bnd_vec_t    v[$];
    logic [31:0] insn;
    logic        err;
    bit          ok;
    int          exp_errs = 1;  // the odd branch offset from test_b_format
    v.push_back('{fmt: FMT_I,      op: 7'h13, imm: 32'hFFFF_F800, exp: 32'h8000_0013, err: 1'b0});
    v.push_back('{fmt: FMT_I,      op: 7'h13, imm: 32'h0000_07FF, exp: 32'h7FF0_0013, err: 1'b0});
    v.push_back('{fmt: FMT_I,      op: 7'h13, imm: 32'h0000_0800, exp: 32'h0000_0013, err: 1'b1});
    v.push_back('{fmt: FMT_S,      op: 7'h23, imm: 32'hFFFF_F7FF, exp: 32'h0000_0013, err: 1'b1});
    v.push_back('{fmt: FMT_ISHIFT, op: 7'h13, imm: 32'h0000_001F, exp: 32'h01F0_0013, err: 1'b0});
    v.push_back('{fmt: FMT_ISHIFT, op: 7'h13, imm: 32'h0000_0020, exp: 32'h0000_0013, err: 1'b1});
    v.push_back('{fmt: FMT_ISHIFT, op: 7'h13, imm: 32'hFFFF_FFFF, exp: 32'h0000_0013, err: 1'b1});
    v.push_back('{fmt: FMT_B,      op: 7'h63, imm: 32'h0000_0FFE, exp: 32'h7E00_0FE3, err: 1'b0});
    v.push_back('{fmt: FMT_B,      op: 7'h63, imm: 32'hFFFF_F000, exp: 32'h8000_0063, err: 1'b0});
    v.push_back('{fmt: FMT_B,      op: 7'h63, imm: 32'h0000_1000, exp: 32'h0000_0013, err: 1'b1});
    v.push_back('{fmt: FMT_B,      op: 7'h63, imm: 32'hFFFF_EFFE, exp: 32'h0000_0013, err: 1'b1});
    v.push_back('{fmt: FMT_J,      op: 7'h6F, imm: 32'h000F_FFFE, exp: 32'h7FFF_F06F, err: 1'b0});
    v.push_back('{fmt: FMT_J,      op: 7'h6F, imm: 32'hFFF0_0000, exp: 32'h8000_006F, err: 1'b0});
    v.push_back('{fmt: FMT_J,      op: 7'h6F, imm: 32'h0010_0000, exp: 32'h0000_0013, err: 1'b1});
    v.push_back('{fmt: FMT_J,      op: 7'h6F, imm: 32'h0000_0001, exp: 32'h0000_0013, err: 1'b1});
    v.push_back('{fmt: FMT_U,      op: 7'h37, imm: 32'hFFFF_F000, exp: 32'hFFFF_F037, err: 1'b0});
    v.push_back('{fmt: FMT_U,      op: 7'h37, imm: 32'h0000_0800, exp: 32'h0000_0013, err: 1'b1});
    v.push_back('{fmt: FMT_R,      op: 7'h33, imm: 32'hDEAD_BEEF, exp: 32'h0000_0033, err: 1'b0});
    v.push_back('{fmt: ImmFmt'(3'd7), op: 7'h13, imm: 32'h0000_0000, exp: 32'h0000_0013, err: 1'b1});
    foreach (v[i]) begin
      run_one(mk(v[i].fmt, v[i].op, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, v[i].imm), insn, err, ok);
      if (v[i].err) exp_errs++;
      n_tests++;
      if (!ok || insn !== v[i].exp || err !== v[i].err) begin
        n_fail++;
        $display("FAIL boundary[%0d] fmt=%0d imm=%08h: ok=%0b insn=%08h err=%0b want insn=%08h err=%0b",
                 i, v[i].fmt, v[i].imm, ok, insn, err, v[i].exp, v[i].err);
      end
    end
    n_tests++;
    if (err_count !== 16'(exp_errs)) begin
      n_fail++; $display("FAIL boundary_err_count: got %0d want %0d", err_count, exp_errs);
    end
  endtask

  task automatic test_back_to_back();
    tb_req_t     reqs[4];
    logic [31:0] exp[4];
    logic [31:0] got[$];
    int          sent = 0;
    int          stall_left = 0;
    int          stall_seen = 0;
    bit          first_done = 1'b0;
    int          extra = 0;
    reqs[0] = mk(FMT_R,      7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0);
    reqs[1] = mk(FMT_S,      7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8);
    reqs[2] = mk(FMT_ISHIFT, 7'h13, 5'd5, 5'd6, 5'd0, 3'd5, 7'h20, 32'd3);
    reqs[3] = mk(FMT_U,      7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000);
    exp[0] = 32'h0020_81B3;
    exp[1] = 32'h0020_A423;
    exp[2] = 32'h4033_5293;
    exp[3] = 32'h1234_52B7;
    for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
      if (sent < 4) begin
        drive(reqs[sent]);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = (stall_left == 0);
      @(negedge clk);
      if (!bus.out_ready) begin
        stall_seen++;
        stall_left--;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_insn !== exp[1]) begin
          n_fail++;
          $display("FAIL b2b_hold[%0d]: valid=%0b insn=%08h want valid=1 insn=%08h",
                   stall_seen, bus.out_valid, bus.out_insn, exp[1]);
        end
        n_tests++;
        if (bus.in_ready !== 1'b0) begin
          n_fail++; $display("FAIL b2b_in_ready_stall[%0d]: got %0b want 0", stall_seen, bus.in_ready);
        end
      end
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) begin
        got.push_back(bus.out_insn);
        if (!first_done) begin
          first_done = 1'b1;
          stall_left = 3;
        end
      end
      next_cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n_tests++;
    if (stall_seen != 3) begin
      n_fail++; $display("FAIL b2b_stall_cycles: got %0d want 3", stall_seen);
    end
    n_tests++;
    if (got.size() != 4) begin
      n_fail++; $display("FAIL b2b_count: got %0d words want 4", got.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        n_tests++;
        if (got[i] !== exp[i]) begin
          n_fail++; $display("FAIL b2b_word[%0d]: got %08h want %08h", i, got[i], exp[i]);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
      next_cycle();
    end
    n_tests++;
    if (extra != 0) begin
      n_fail++; $display("FAIL b2b_no_duplicate: got %0d extra valid cycles want 0", extra);
    end
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    bus.out_ready = 1'b0;
    drive(mk(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF));
    bus.in_valid = 1'b1;
    next_cycle();
    drive(mk(ImmFmt'(3'd7), 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0));
    next_cycle();
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_full: out_valid=%0b in_ready=%0b want 1 0", bus.out_valid, bus.in_ready);
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_in_ready: got %0b want 0", bus.in_ready);
    end
    next_cycle();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || err_count !== 16'd0 || bus.out_insn !== 32'd0 || bus.out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_cleared: valid=%0b cnt=%0d insn=%08h err=%0b want 0 0 00000000 0",
               bus.out_valid, err_count, bus.out_insn, bus.out_err);
    end
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_in_ready_after: got %0b want 1", bus.in_ready);
    end
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) stale++;
      next_cycle();
      @(negedge clk);
    end
    next_cycle();
    n_tests++;
    if (stale != 0) begin
      n_fail++; $display("FAIL rstmid_stale: got %0d valid cycles want 0", stale);
    end
  endtask

  task automatic test_saturation();
    int hs = 0;
    bit done = 1'b0;
    drive(mk(ImmFmt'(3'd7), 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0));
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 66000 && !done; cyc++) begin
      @(negedge clk);
      if (hs == 65534) begin
        n_tests++;
        if (err_count !== 16'hFFFE) begin
          n_fail++; $display("FAIL sat_fffe: got %04h want fffe", err_count);
        end
      end
      if (hs == 65535) begin
        n_tests++;
        if (err_count !== 16'hFFFF) begin
          n_fail++; $display("FAIL sat_ffff: got %04h want ffff", err_count);
        end
      end
      if (hs == 65540) begin
        done = 1'b1;
        n_tests++;
        if (err_count !== 16'hFFFF) begin
          n_fail++; $display("FAIL sat_hold: got %04h want ffff", err_count);
        end
      end
      if (!done && bus.out_valid && bus.out_ready) hs++;
    end
    bus.in_valid = 1'b0;
    next_cycle();
    n_tests++;
    if (!done) begin
      n_fail++; $display("FAIL sat_timeout: got %0d handshakes want 65540", hs);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_i_latency();
    test_b_format();
    test_j_u_format();
    test_r_s_shift();
    test_boundaries();
    test_back_to_back();
    test_reset_midflight();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
